// File: rtl/mips_insn_encoder.sv
// Encodes symbolic MIPS32 requests into instruction words and streams them into
// an instruction memory at an auto-incrementing address; LI expands to LUI/ORI.
module mips_insn_encoder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [31:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic [ADDR_W:0]   wr_ptr,
  output logic              full,
  output logic              overflow,
  output logic              illegal
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT2, S_FULL} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W:0]   r_wr_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [31:0]       r_pend;
  logic              r_overflow;
  logic              r_illegal;

  logic [31:0]       w_word0;
  logic [31:0]       w_word1;
  logic [1:0]        w_nwords;
  logic              w_illegal;
  logic              w_ready;
  logic              w_write;
  logic [31:0]       w_wdata;
  logic              w_set_ovf;
  logic              w_set_ill;
  logic              w_load_pend;
  logic [ADDR_W:0]   w_ptr_inc;

  function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] f_i(input logic [5:0] opc, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] im);
    return {opc, rs, rt, im};
  endfunction

  // Instruction encoding of the request currently on the inputs.
  always_comb begin
    w_word0   = '0;
    w_word1   = '0;
    w_nwords  = 2'd1;
    w_illegal = 1'b0;
    case (req_op)
      5'd0:  w_word0 = 32'h0000_000D;
      5'd1:  w_word0 = f_r(req_rs, req_rt, req_rd, 5'd0, 6'd32);
      5'd2:  w_word0 = f_r(req_rs, req_rt, req_rd, 5'd0, 6'd34);
      5'd3:  w_word0 = f_r(req_rs, req_rt, req_rd, 5'd0, 6'd36);
      5'd4:  w_word0 = f_r(req_rs, req_rt, req_rd, 5'd0, 6'd37);
      5'd5:  w_word0 = f_r(req_rs, req_rt, req_rd, 5'd0, 6'd38);
      5'd6:  w_word0 = f_r(req_rs, req_rt, req_rd, 5'd0, 6'd39);
      5'd7:  w_word0 = f_r(req_rs, req_rt, req_rd, 5'd0, 6'd42);
      5'd8:  w_word0 = f_r(5'd0, req_rt, req_rd, req_imm[4:0], 6'd0);
      5'd9:  w_word0 = f_r(5'd0, req_rt, req_rd, req_imm[4:0], 6'd2);
      5'd10: w_word0 = f_r(5'd0, req_rt, req_rd, req_imm[4:0], 6'd3);
      5'd11: w_word0 = f_r(req_rs, req_rt, req_rd, 5'd0, 6'd4);
      5'd12: w_word0 = f_r(req_rs, req_rt, req_rd, 5'd0, 6'd6);
      5'd13: w_word0 = f_r(req_rs, req_rt, req_rd, 5'd0, 6'd7);
      5'd14: w_word0 = f_i(6'd8,  req_rs, req_rt, req_imm[15:0]);
      5'd15: w_word0 = f_i(6'd10, req_rs, req_rt, req_imm[15:0]);
      5'd16: w_word0 = f_i(6'd12, req_rs, req_rt, req_imm[15:0]);
      5'd17: w_word0 = f_i(6'd13, req_rs, req_rt, req_imm[15:0]);
      5'd18: w_word0 = f_i(6'd14, req_rs, req_rt, req_imm[15:0]);
      5'd19: w_word0 = f_i(6'd15, 5'd0,   req_rt, req_imm[15:0]);
      5'd20: w_word0 = f_i(6'd35, req_rs, req_rt, req_imm[15:0]);
      5'd21: w_word0 = f_i(6'd43, req_rs, req_rt, req_imm[15:0]);
      5'd22: w_word0 = f_i(6'd4,  req_rs, req_rt, req_imm[15:0]);
      5'd23: w_word0 = {6'd2, req_imm[25:0]};
      5'd24: begin
        // Shortest LI form wins; a zero immediate takes the ORI path.
        if (req_imm[31:16] == 16'd0) begin
          w_word0 = f_i(6'd13, 5'd0, req_rt, req_imm[15:0]);
        end else if (req_imm[15:0] == 16'd0) begin
          w_word0 = f_i(6'd15, 5'd0, req_rt, req_imm[31:16]);
        end else begin
          w_word0  = f_i(6'd15, 5'd0, req_rt, req_imm[31:16]);
          w_word1  = f_i(6'd13, req_rt, req_rt, req_imm[15:0]);
          w_nwords = 2'd2;
        end
      end
      default: begin
        w_illegal = 1'b1;
        w_nwords  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_write      = 1'b0;
    w_wdata      = r_pend;
    w_set_ovf    = 1'b0;
    w_set_ill    = 1'b0;
    w_load_pend  = 1'b0;
    w_ptr_inc    = r_wr_ptr + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_ready = (r_wr_ptr != LP_DEPTH);
        if (req_valid && w_ready && !clear) begin
          if (w_illegal) begin
            w_set_ill = 1'b1;
          end else if (w_nwords == 2'd2 && r_wr_ptr == LP_LAST) begin
            w_set_ovf = 1'b1;
          end else begin
            w_write = 1'b1;
            w_wdata = w_word0;
            if (w_nwords == 2'd2) begin
              w_load_pend  = 1'b1;
              w_state_next = S_EMIT2;
            end else if (w_ptr_inc == LP_DEPTH) begin
              w_state_next = S_FULL;
            end
          end
        end
      end
      S_EMIT2: begin
        w_write      = 1'b1;
        w_state_next = (w_ptr_inc == LP_DEPTH) ? S_FULL : S_IDLE;
      end
      default: begin
        w_state_next = S_FULL;
      end
    endcase
    if (clear) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_pend     <= '0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_pend     <= '0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_addr   <= r_wr_ptr[ADDR_W-1:0];
        r_data   <= w_wdata;
        r_wr_ptr <= w_ptr_inc;
      end
      if (w_load_pend) begin
        r_pend <= w_word1;
      end
      if (w_set_ovf) begin
        r_overflow <= 1'b1;
      end
      if (w_set_ill) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign req_ready = w_ready;
  assign imem_we   = r_we;
  assign imem_addr = r_addr;
  assign imem_data = r_data;
  assign wr_ptr    = r_wr_ptr;
  assign full      = (r_wr_ptr == LP_DEPTH);
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_mips_insn_encoder.sv
// Randomized and directed checks of mips_insn_encoder against a word-queue model.
module tb_mips_insn_encoder;
  localparam int AW  = 2;
  localparam int DEP = 4;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [4:0]    req_rd;
  logic [4:0]    req_rs;
  logic [4:0]    req_rt;
  logic [31:0]   req_imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [AW:0]   wr_ptr;
  logic          full;
  logic          overflow;
  logic          illegal;

  int total = 0;
  int bad   = 0;

  // Model: pointer, sticky flags, last write and words still owed to memory.
  int          m_ptr;
  bit          m_ovf;
  bit          m_ill;
  bit          m_we;
  int          m_addr;
  bit [31:0]   m_data;
  bit [31:0]   pend[$];

  mips_insn_encoder #(.ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt),
    .req_imm(req_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .wr_ptr(wr_ptr), .full(full), .overflow(overflow), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns number of words (0 = illegal) for an operation, from the ISA tables.
  task automatic mdl_encode(input int op, input bit [31:0] rd, input bit [31:0] rs,
                            input bit [31:0] rt, input bit [31:0] imm,
                            output int n, output bit [31:0] w0, output bit [31:0] w1);
    bit [31:0] hi;
    bit [31:0] lo;
    bit [31:0] fn;
    bit [31:0] opc;
    n  = 1;
    w0 = 0;
    w1 = 0;
    fn = 0;
    opc = 0;
    hi = imm >> 16;
    lo = imm & 32'hFFFF;
    if (op == 0) begin
      w0 = 13;
    end else if (op >= 1 && op <= 7) begin
      case (op)
        1: fn = 32; 2: fn = 34; 3: fn = 36; 4: fn = 37;
        5: fn = 38; 6: fn = 39; default: fn = 42;
      endcase
      w0 = (rs << 21) + (rt << 16) + (rd << 11) + fn;
    end else if (op >= 8 && op <= 10) begin
      fn = (op == 8) ? 0 : (op == 9) ? 2 : 3;
      w0 = (rt << 16) + (rd << 11) + ((imm % 32) << 6) + fn;
    end else if (op >= 11 && op <= 13) begin
      fn = (op == 11) ? 4 : (op == 12) ? 6 : 7;
      w0 = (rs << 21) + (rt << 16) + (rd << 11) + fn;
    end else if (op >= 14 && op <= 22) begin
      case (op)
        14: opc = 8;  15: opc = 10; 16: opc = 12; 17: opc = 13; 18: opc = 14;
        19: opc = 15; 20: opc = 35; 21: opc = 43; default: opc = 4;
      endcase
      if (op == 19) rs = 0;
      w0 = (opc << 26) + (rs << 21) + (rt << 16) + lo;
    end else if (op == 23) begin
      w0 = (2 << 26) + (imm % (1 << 26));
    end else if (op == 24) begin
      if (hi == 0) begin
        w0 = (13 << 26) + (rt << 16) + lo;
      end else if (lo == 0) begin
        w0 = (15 << 26) + (rt << 16) + hi;
      end else begin
        n  = 2;
        w0 = (15 << 26) + (rt << 16) + hi;
        w1 = (13 << 26) + (rt << 21) + (rt << 16) + lo;
      end
    end else begin
      n = 0;
    end
  endtask

  task automatic mdl_write(input bit [31:0] w);
    m_we   = 1'b1;
    m_addr = m_ptr;
    m_data = w;
    m_ptr++;
  endtask

  task automatic mdl_reset();
    m_ptr = 0;
    m_ovf = 1'b0;
    m_ill = 1'b0;
    m_we  = 1'b0;
    pend.delete();
  endtask

  task automatic mdl_step(input bit clr, input bit val, input int op, input int rd,
                          input int rs, input int rt, input bit [31:0] imm);
    int        n;
    bit [31:0] w0;
    bit [31:0] w1;
    bit        rdy;
    rdy  = (pend.size() == 0) && (m_ptr < DEP);
    m_we = 1'b0;
    if (clr) begin
      mdl_reset();
    end else if (pend.size() > 0) begin
      mdl_write(pend.pop_front());
    end else if (val && rdy) begin
      mdl_encode(op, rd, rs, rt, imm, n, w0, w1);
      if (n == 0) begin
        m_ill = 1'b1;
      end else if (n == 2 && DEP - m_ptr == 1) begin
        m_ovf = 1'b1;
      end else begin
        mdl_write(w0);
        if (n == 2) pend.push_back(w1);
      end
    end
  endtask

  task automatic check_all();
    chk("we", 32'(imem_we), 32'(m_we));
    if (m_we) begin
      chk("addr", 32'(imem_addr), 32'(m_addr));
      chk("data", imem_data, m_data);
    end
    chk("wr_ptr", 32'(wr_ptr), 32'(m_ptr));
    chk("full", 32'(full), 32'(m_ptr == DEP));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("ready", 32'(req_ready), 32'((pend.size() == 0) && (m_ptr < DEP)));
  endtask

  // Drive one cycle at the falling edge, advance model, check at the next falling edge.
  task automatic cyc(input bit clr, input bit val, input int op, input int rd,
                     input int rs, input int rt, input bit [31:0] imm);
    clear     = clr;
    req_valid = val;
    req_op    = 5'(op);
    req_rd    = 5'(rd);
    req_rs    = 5'(rs);
    req_rt    = 5'(rt);
    req_imm   = imm;
    mdl_step(clr, val, op, rd, rs, rt, imm);
    @(posedge clk);
    @(negedge clk);
    $display("cyc clr=%0d val=%0d op=%0d imm=%h -> we=%0d addr=%0d data=%h ptr=%0d",
             clr, val, op, imm, imem_we, imem_addr, imem_data, wr_ptr);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; req_valid = 1'b0;
    req_op = '0; req_rd = '0; req_rs = '0; req_rt = '0; req_imm = '0;
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    chk("rst_data", imem_data, 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    reset = 1'b0;

    // Single R-type.
    cyc(1'b0, 1'b1, 1, 3, 1, 2, 32'h0);
    chk("add_word", imem_data, 32'h0022_1820);
    idle();

    // Two-word LI: ready drops for exactly one cycle; a request then is ignored.
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 32'h0);
    cyc(1'b0, 1'b1, 24, 0, 0, 8, 32'h1234_5678);
    chk("li_hi", imem_data, 32'h3C08_1234);
    chk("li_busy", 32'(req_ready), 32'h0);
    cyc(1'b0, 1'b1, 1, 3, 1, 2, 32'h0);
    chk("li_lo", imem_data, 32'h3508_5678);
    chk("li_lo_addr", 32'(imem_addr), 32'h1);
    chk("li_ready_back", 32'(req_ready), 32'h1);

    // Single-word forms, then LI overflow with one slot left, then fill.
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 32'h0);
    cyc(1'b0, 1'b1, 24, 0, 0, 8, 32'h0000_0042);
    chk("li_small", imem_data, 32'h3408_0042);
    cyc(1'b0, 1'b1, 20, 0, 29, 4, 32'h0000_0010);
    chk("lw", imem_data, 32'h8FA4_0010);
    cyc(1'b0, 1'b1, 23, 0, 0, 0, 32'h0000_0100);
    chk("j", imem_data, 32'h0800_0100);
    cyc(1'b0, 1'b1, 24, 0, 0, 8, 32'h1234_5678);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_ptr", 32'(wr_ptr), 32'h3);
    cyc(1'b0, 1'b1, 1, 3, 1, 2, 32'h0);
    chk("last_addr", 32'(imem_addr), 32'h3);
    chk("full_flag", 32'(full), 32'h1);
    cyc(1'b0, 1'b1, 1, 3, 1, 2, 32'h0);

    // Back-to-back fill from empty.
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 2 + k, k, k + 1, k + 2, 32'h0);

    // Illegal op, clear, clear vs. request, clear during EMIT2.
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 32'h0);
    cyc(1'b0, 1'b1, 27, 1, 1, 1, 32'h0);
    chk("illegal_flag", 32'(illegal), 32'h1);
    cyc(1'b1, 1'b1, 1, 3, 1, 2, 32'h0);
    chk("clear_wins", 32'(wr_ptr), 32'h0);
    cyc(1'b0, 1'b1, 24, 0, 0, 9, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b0, 0, 0, 0, 0, 32'h0);

    // Asynchronous reset while EMIT2 is pending.
    cyc(1'b0, 1'b1, 24, 0, 0, 8, 32'h1234_5678);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_we", 32'(imem_we), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h1);
    chk("arst_ptr", 32'(wr_ptr), 32'h0);
    mdl_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      bit        clr;
      bit        val;
      int        op;
      bit [31:0] r;
      bit [31:0] imm;
      int        sel;
      clr = ($urandom_range(0, 14) == 0);
      val = ($urandom_range(0, 3) != 0);
      op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(25, 31))
                                        : int'($urandom_range(0, 24));
      r   = $urandom;
      sel = $urandom_range(0, 3);
      imm = (sel == 0) ? (r & 32'h0000_FFFF) : (sel == 1) ? (r & 32'hFFFF_0000) : r;
      cyc(clr, val, op, $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), imm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
